// File: rtl/gb_irq_pkg.sv
// Shared constants, state type and vector helper for the Game Boy
// interrupt controller and the CPU halt logic.
package gb_irq_pkg;

  localparam int IRQ_VBLANK = 0;
  localparam int IRQ_STAT   = 1;
  localparam int IRQ_TIMER  = 2;
  localparam int IRQ_SERIAL = 3;
  localparam int IRQ_JOYPAD = 4;

  localparam int         NUM_SRC    = 5;
  localparam logic [7:0] VEC_BASE   = 8'h40;
  localparam logic [7:0] VEC_STRIDE = 8'd8;

  typedef enum logic {
    IDLE,
    ACKED
  } irq_state_e;

  function automatic logic [7:0] irq_vec(
    input logic [7:0] base,
    input logic [7:0] stride,
    input logic [7:0] idx
  );
    return base + stride * idx;
  endfunction

endpackage

// File: rtl/gb_irq_prio_enc.sv
// Lowest-index-wins priority encoder over the pending interrupt mask.
// Purely combinational so the CPU halt-wake path can reuse it.
module gb_irq_prio_enc #(
  parameter int N  = 5,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  pending_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  always_comb begin
    valid_o = |pending_i;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pending_i[i]) idx_o = IW'(i);
    end
  end

endmodule

// File: rtl/gb_irq_ctrl.sv
// Game Boy interrupt controller: IF/IE registers, CPU line, ack vector.
// GB_IRQ_CTRL_SYNC_DELAY_EN registers cpu_irq_n on ce (one ce later).
module gb_irq_ctrl #(
  parameter int         NUM_SRC    = gb_irq_pkg::NUM_SRC,
  parameter logic [7:0] VEC_BASE   = gb_irq_pkg::VEC_BASE,
  parameter logic [7:0] VEC_STRIDE = gb_irq_pkg::VEC_STRIDE
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               ce,
  input  logic [NUM_SRC-1:0] irq_req,
  input  logic               cpu_sel_if,
  input  logic               cpu_sel_ie,
  input  logic               cpu_wr,
  input  logic [7:0]         cpu_di,
  output logic [7:0]         cpu_do,
  output logic               cpu_irq_n,
  input  logic               cpu_ack,
  output logic [7:0]         cpu_vector
);

  import gb_irq_pkg::*;

  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0] if_q, if_d;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] clr;
  logic [7:0]         ie_q, ie_d;
  logic [7:0]         vec_q, vec_d;
  irq_state_e         state_q, state_d;
  logic               take;
  logic               p_valid;
  logic [IW-1:0]      p_idx;

  assign pending = if_q & ie_q[NUM_SRC-1:0];

  gb_irq_prio_enc #(
    .N  (NUM_SRC),
    .IW (IW)
  ) u_prio (
    .pending_i (pending),
    .valid_o   (p_valid),
    .idx_o     (p_idx)
  );

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ce && cpu_ack) begin
          state_d = ACKED;
          take    = 1'b1;
        end
      end
      ACKED: begin
        if (ce && !cpu_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request beats CPU write beats ack clear, bit by bit.
  always_comb begin
    clr   = '0;
    vec_d = vec_q;
    if_d  = if_q;
    ie_d  = ie_q;
    if (take) begin
      if (p_valid) begin
        clr[p_idx] = 1'b1;
        vec_d      = irq_vec(VEC_BASE, VEC_STRIDE, 8'(p_idx));
      end else begin
        vec_d = 8'h00;
      end
    end
    if (ce) begin
      if_d = if_q & ~clr;
      if (cpu_wr && cpu_sel_if) if_d = cpu_di[NUM_SRC-1:0];
      if_d = if_d | irq_req;
      if (cpu_wr && cpu_sel_ie) ie_d = cpu_di;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
      if_q    <= '0;
      ie_q    <= 8'h00;
      vec_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      if_q    <= if_d;
      ie_q    <= ie_d;
      vec_q   <= vec_d;
    end
  end

`ifdef GB_IRQ_CTRL_SYNC_DELAY_EN
  logic irq_n_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      irq_n_q <= 1'b1;
    end else if (ce) begin
      irq_n_q <= ~|pending;
    end
  end

  assign cpu_irq_n = irq_n_q;
`else
  assign cpu_irq_n = ~|pending;
`endif

  always_comb begin
    cpu_do = 8'hFF;
    if (cpu_sel_if) begin
      cpu_do = {{(8 - NUM_SRC){1'b1}}, if_q};
    end else if (cpu_sel_ie) begin
      cpu_do = ie_q;
    end
  end

  assign cpu_vector = vec_q;

endmodule

// File: tb/tb_gb_irq_ctrl.sv
// Directed bench for gb_irq_ctrl: IF/IE access, priority, ack races,
// reset mid-dispatch and the optional registered cpu_irq_n.
module tb_gb_irq_ctrl;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic       ce;
  logic [4:0] irq_req;
  logic       cpu_sel_if;
  logic       cpu_sel_ie;
  logic       cpu_wr;
  logic [7:0] cpu_di;
  logic [7:0] cpu_do;
  logic       cpu_irq_n;
  logic       cpu_ack;
  logic [7:0] cpu_vector;

  int n_chk  = 0;
  int n_pass = 0;

  gb_irq_ctrl dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ce         (ce),
    .irq_req    (irq_req),
    .cpu_sel_if (cpu_sel_if),
    .cpu_sel_ie (cpu_sel_ie),
    .cpu_wr     (cpu_wr),
    .cpu_di     (cpu_di),
    .cpu_do     (cpu_do),
    .cpu_irq_n  (cpu_irq_n),
    .cpu_ack    (cpu_ack),
    .cpu_vector (cpu_vector)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wr(input logic sel_if, input logic [7:0] d);
    ce         = 1'b1;
    cpu_wr     = 1'b1;
    cpu_sel_if = sel_if;
    cpu_sel_ie = !sel_if;
    cpu_di     = d;
    cyc();
    cpu_wr     = 1'b0;
    cpu_sel_if = 1'b0;
    cpu_sel_ie = 1'b0;
  endtask

  task automatic rd(input string tag, input logic sel_if,
                    input logic [7:0] exp);
    cpu_sel_if = sel_if;
    cpu_sel_ie = !sel_if;
    #1;
    chk(tag, cpu_do, exp);
    cpu_sel_if = 1'b0;
    cpu_sel_ie = 1'b0;
  endtask

  task automatic step(input logic a, input logic [4:0] req);
    ce      = 1'b1;
    cpu_ack = a;
    irq_req = req;
    cyc();
    irq_req = '0;
  endtask

  initial begin
    reset      = 1'b1;
    ce         = 1'b1;
    irq_req    = '0;
    cpu_sel_if = 1'b0;
    cpu_sel_ie = 1'b0;
    cpu_wr     = 1'b0;
    cpu_di     = 8'h00;
    cpu_ack    = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    chk("rst_irq_n", 8'(cpu_irq_n), 8'h01);
    chk("rst_vec", cpu_vector, 8'h00);
    rd("rst_if", 1'b1, 8'hE0);
    rd("rst_ie", 1'b0, 8'h00);

    // request without ce is not sampled
    ce      = 1'b0;
    irq_req = 5'h04;
    cyc();
    irq_req = '0;
    rd("no_ce_if", 1'b1, 8'hE0);

    // timer pulse then dispatch
    wr(1'b0, 8'h04);
    step(1'b0, 5'h04);
    rd("tmr_if", 1'b1, 8'hE4);
`ifdef GB_IRQ_CTRL_SYNC_DELAY_EN
    chk("tmr_irq_n_dly", 8'(cpu_irq_n), 8'h01);
`else
    chk("tmr_irq_n", 8'(cpu_irq_n), 8'h00);
`endif
    step(1'b0, 5'h00);
    chk("tmr_irq_n2", 8'(cpu_irq_n), 8'h00);
    step(1'b1, 5'h00);
    chk("tmr_vec", cpu_vector, 8'h50);
    rd("tmr_if_clr", 1'b1, 8'hE0);
`ifdef GB_IRQ_CTRL_SYNC_DELAY_EN
    chk("tmr_ack_irq_n_dly", 8'(cpu_irq_n), 8'h00);
`else
    chk("tmr_ack_irq_n", 8'(cpu_irq_n), 8'h01);
`endif
    step(1'b0, 5'h00);
    chk("tmr_rel_irq_n", 8'(cpu_irq_n), 8'h01);
    chk("tmr_vec_hold", cpu_vector, 8'h50);

    // all pending: priority order, no second clear while held
    wr(1'b1, 8'h1F);
    wr(1'b0, 8'h1F);
    step(1'b1, 5'h00);
    chk("pri_vec0", cpu_vector, 8'h40);
    step(1'b1, 5'h00);
    rd("pri_hold_if", 1'b1, 8'hFE);
    step(1'b0, 5'h00);
    step(1'b1, 5'h00);
    chk("pri_vec1", cpu_vector, 8'h48);
    step(1'b0, 5'h00);
    step(1'b1, 5'h00);
    chk("pri_vec2", cpu_vector, 8'h50);
    step(1'b0, 5'h00);
    rd("pri_if_end", 1'b1, 8'hF8);

    // request beats simultaneous write of zero
    ce         = 1'b1;
    cpu_wr     = 1'b1;
    cpu_sel_if = 1'b1;
    cpu_di     = 8'h00;
    irq_req    = 5'h01;
    cyc();
    irq_req    = '0;
    cpu_wr     = 1'b0;
    cpu_sel_if = 1'b0;
    rd("req_vs_wr", 1'b1, 8'hE1);

    // IE removed before ack: null vector, nothing cleared
    wr(1'b0, 8'h00);
    step(1'b1, 5'h00);
    chk("null_vec", cpu_vector, 8'h00);
    rd("null_if", 1'b1, 8'hE1);
    step(1'b0, 5'h00);
    chk("null_irq_n", 8'(cpu_irq_n), 8'h01);

    // request beats ack clear of the same bit
    wr(1'b1, 8'h04);
    wr(1'b0, 8'h04);
    step(1'b1, 5'h04);
    chk("race_vec", cpu_vector, 8'h50);
    rd("race_if", 1'b1, 8'hE4);
    chk("race_irq_n", 8'(cpu_irq_n), 8'h00);
    step(1'b0, 5'h00);

    // reset while ACKED
    wr(1'b0, 8'h1F);
    wr(1'b1, 8'h03);
    step(1'b1, 5'h00);
    chk("ra_vec", cpu_vector, 8'h40);
    reset = 1'b1;
    cyc();
    reset   = 1'b0;
    cpu_ack = 1'b0;
    rd("ra_if", 1'b1, 8'hE0);
    rd("ra_ie", 1'b0, 8'h00);
    chk("ra_irq_n", 8'(cpu_irq_n), 8'h01);
    chk("ra_vec_rst", cpu_vector, 8'h00);
    wr(1'b0, 8'h08);
    wr(1'b1, 8'h08);
    step(1'b1, 5'h00);
    chk("ra_idle_vec", cpu_vector, 8'h58);
    rd("ra_idle_if", 1'b1, 8'hE0);
    step(1'b0, 5'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
